fetch_stream: RTL
=================

Name: fetch_stream

Overview:
- Parametrised front-end fetch unit: PC generator, in-order I-cache request/response tracker and instruction queue in one block.
- Adds three things a single-slot fetch path lacks: up to DEPTH outstanding requests, branch redirect with squash of in-flight responses, and a ready/ack handshake to decode.
- Sits between the back-end redirect source, the I-cache and the decode stage.

Parameters:
- ADDR, 32, address width.
- DATA, 32, instruction width; PC increment = DATA/8.
- DEPTH, 4, queue entries and maximum in-flight requests; power of two, >=2.
- RESET_PC, 0, PC loaded on reset.

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous, active-low reset.
- br_e_  in  1  redirect valid, active-low.
- br_target  in  ADDR  redirect target PC.
- fetch_e_  out  1  I-cache request valid, active-low.
- fetch_pc  out  ADDR  request address.
- ic_ready_  in  1  I-cache accepts request this cycle, active-low.
- ic_e_  in  1  I-cache response valid, active-low.
- ic_pc  in  ADDR  response PC.
- ic_inst  in  DATA  response instruction.
- inst_e_  out  1  queue head valid to decode, active-low.
- inst_pc  out  ADDR  head PC.
- inst  out  DATA  head instruction.
- inst_ack_  in  1  decode consumes head, active-low.
- fq_cnt  out  $clog2(DEPTH)+1  queue occupancy.

Behaviour:
- Reset (async, any time): pc=RESET_PC; occ=0; live=0; drop=0; fetch_e_=1; inst_e_=1; inst_pc=0; inst=0; fq_cnt=0. The I-cache shares reset_, so no response survives reset.
- State:
  - pc: next fetch address.
  - occ: queue entries.
  - live: outstanding requests whose responses will be kept.
  - drop: outstanding requests whose responses will be discarded.
- Request:
  - fetch_e_ = ~(occ+live+drop < DEPTH) | ~br_e_; fetch_pc = pc.
  - Accepted when fetch_e_==0 && ic_ready_==0; then pc <= pc+DATA/8 (mod 2^ADDR, wraps) and live++.
  - Not accepted: pc held, request repeats.
- Response (ic_e_==0, responses in request order):
  - drop>0: discard, drop--.
  - else live>0: enqueue {ic_pc, ic_inst} at tail, live--.
  - live==drop==0: ignore (protocol violation, no state change).
- Dequeue:
  - inst_e_ = (occ==0) | ~br_e_; inst_pc/inst = head entry.
  - inst_ack_==0 && inst_e_==0: head advances, occ--.
  - Ack while inst_e_==1: ignored.
- No bypass: a response at cycle t appears at inst_e_ at t+1 at the earliest.
- Enqueue and dequeue in the same cycle: occ unchanged, both pointers advance.
- Redirect (br_e_==0 at cycle t) has priority over everything else:
  - pc <= br_target.
  - Queue flushed: occ=0, pointers reset.
  - No request issued and no dequeue at t.
  - drop <= drop+live-(ic_e_==0 ? 1:0); live <= 0. A response at t is stale and discarded.
  - fetch_pc=br_target with fetch_e_ low at t+1 if credit allows.
- Back-to-back redirects: the last one wins; each re-computes drop.
- Credit invariant: occ+live+drop <= DEPTH at all times, so enqueue never overflows.
- Pointers are log2(DEPTH) bits and wrap naturally.
- fq_cnt = occ.

Test Plan:
- Reset release, ic_ready_=0, 1-cycle-later responses, inst_ack_=0 every cycle -> fetch_pc 0,4,8,...; inst_pc stream 0,4,8 in order; fq_cnt never exceeds 2.
- DEPTH=4, inst_ack_=1 held, cache always ready -> exactly 4 requests (0,4,8,C), fetch_e_ then stays 1; fq_cnt=4; one ack -> next request 0x10 on the following cycle.
- 3 requests outstanding (0,4,8), no responses, redirect to 0x100 -> drop=3; three responses discarded; the first enqueued inst_pc is 0x100.
- Redirect in the same cycle as a response for PC 4 with live=2 -> that response is discarded, drop=1, queue empty, fetch_pc=target next cycle.
- ic_ready_=1 for 5 cycles -> fetch_pc held constant, live unchanged; request completes when ic_ready_ drops.
- Assert reset_ mid-stream with occ=3 -> all outputs at reset values immediately (async); after release the first fetch_pc is RESET_PC.

Source files
------------

// File: rtl/fetch_stream_if.sv
// Signal bundle between fetch_stream and its neighbours: redirect source,
// I-cache request/response channel and the decode-side instruction handshake.
interface fetch_stream_if #(
    parameter int ADDR  = 32,
    parameter int DATA  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            br_e_;
    logic [ADDR-1:0] br_target;

    logic            fetch_e_;
    logic [ADDR-1:0] fetch_pc;
    logic            ic_ready_;

    logic            ic_e_;
    logic [ADDR-1:0] ic_pc;
    logic [DATA-1:0] ic_inst;

    logic            inst_e_;
    logic [ADDR-1:0] inst_pc;
    logic [DATA-1:0] inst;
    logic            inst_ack_;

    logic [CW-1:0]   fq_cnt;

    // Fetch unit side.
    modport slave (
        input  br_e_, br_target, ic_ready_, ic_e_, ic_pc, ic_inst, inst_ack_,
        output fetch_e_, fetch_pc, inst_e_, inst_pc, inst, fq_cnt
    );

    // Environment side: back-end, I-cache and decode together.
    modport master (
        output br_e_, br_target, ic_ready_, ic_e_, ic_pc, ic_inst, inst_ack_,
        input  fetch_e_, fetch_pc, inst_e_, inst_pc, inst, fq_cnt
    );
endinterface

// File: rtl/fetch_stream.sv
// Front-end fetch: PC generator, in-order I-cache request tracker with
// redirect squash, and a DEPTH-entry instruction queue feeding decode.
module fetch_stream #(
    parameter int              ADDR     = 32,
    parameter int              DATA     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset_,
    fetch_stream_if.slave bus
);
    localparam int              PW      = $clog2(DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [ADDR-1:0] PC_INC  = ADDR'(DATA / 8);
    localparam logic [CW+1:0]   DEPTH_C = (CW + 2)'(DEPTH);

    logic [ADDR-1:0] pc, pc_n;
    logic [CW-1:0]   occ, occ_n;
    logic [CW-1:0]   live, live_n;
    logic [CW-1:0]   drop, drop_n;
    logic [PW-1:0]   head, head_n;
    logic [PW-1:0]   tail, tail_n;

    logic [ADDR-1:0] mem_pc   [DEPTH];
    logic [DATA-1:0] mem_inst [DEPTH];

    logic            redirect;
    logic            rsp;
    logic            credit_ok;
    logic            fetch_vld;
    logic            inst_vld;
    logic            req_acc;
    logic            drop_rsp;
    logic            enq;
    logic            deq;
    logic            redir_rsp;
    logic [CW+1:0]   inflight;

    // Every request in flight or buffered holds one queue slot, so a kept
    // response can always be enqueued without an overflow check.
    assign inflight  = {2'b00, occ} + {2'b00, live} + {2'b00, drop};
    assign credit_ok = inflight < DEPTH_C;
    assign redirect  = ~bus.br_e_;
    assign rsp       = ~bus.ic_e_;

    // No request while held in reset: the I-cache is in reset alongside us.
    assign fetch_vld = credit_ok & ~redirect & reset_;
    assign inst_vld  = (occ != '0) & ~redirect;

    assign req_acc   = fetch_vld & ~bus.ic_ready_;
    assign drop_rsp  = rsp & ~redirect & (drop != '0);
    assign enq       = rsp & ~redirect & (drop == '0) & (live != '0);
    assign deq       = inst_vld & ~bus.inst_ack_;
    assign redir_rsp = rsp & ((drop != '0) | (live != '0));

    assign bus.fetch_e_ = ~fetch_vld;
    assign bus.fetch_pc = pc;
    assign bus.inst_e_  = ~inst_vld;
    assign bus.inst_pc  = mem_pc[head];
    assign bus.inst     = mem_inst[head];
    assign bus.fq_cnt   = occ;

    always_comb begin
        pc_n   = pc;
        occ_n  = occ;
        live_n = live;
        drop_n = drop;
        head_n = head;
        tail_n = tail;
        if (redirect) begin
            // Everything still in flight becomes stale, including a response
            // arriving this very cycle.
            pc_n   = bus.br_target;
            occ_n  = '0;
            live_n = '0;
            head_n = '0;
            tail_n = '0;
            drop_n = drop + live - CW'(redir_rsp);
        end else begin
            if (req_acc) begin
                pc_n = pc + PC_INC;
            end
            live_n = live + CW'(req_acc) - CW'(enq);
            drop_n = drop - CW'(drop_rsp);
            occ_n  = occ + CW'(enq) - CW'(deq);
            if (enq) begin
                tail_n = tail + 1'b1;
            end
            if (deq) begin
                head_n = head + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            pc   <= RESET_PC;
            occ  <= '0;
            live <= '0;
            drop <= '0;
            head <= '0;
            tail <= '0;
        end else begin
            pc   <= pc_n;
            occ  <= occ_n;
            live <= live_n;
            drop <= drop_n;
            head <= head_n;
            tail <= tail_n;
        end
    end

    // Storage is cleared so the head outputs read zero straight out of reset.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc[i]   <= '0;
                mem_inst[i] <= '0;
            end
        end else if (enq) begin
            mem_pc[tail]   <= bus.ic_pc;
            mem_inst[tail] <= bus.ic_inst;
        end
    end
endmodule
